pe_cfg_sequencer: RTL and testbench
===================================

# pe_cfg_sequencer

Command sequencer that acts as the bus master for the PE configuration port (`cfg_addr`/`cfg_wdata`/`cfg_we`/`cfg_en`/`cfg_rdata`). It accepts queued WRITE / OP / READ commands from a host over a valid/ready interface and drives them onto the PE port. It obeys the PE's one-cycle input latch: the PE captures the address and control on one edge and commits the register write on the next. READ results return to the host over a valid/ready response channel.

## Interface
- `DEPTH`, 8, command FIFO depth; power of two, ≥2.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_type`  in  2  00 WRITE, 01 OP, 10 READ, 11 OPRD (macro) / reserved.
- `cmd_addr`  in  32  PE instruction word (READ/OPRD readback uses bits [4:0]).
- `cmd_wdata`  in  32  write data (WRITE only; don't-care otherwise).
- `rsp_valid`  out  1  read result valid.
- `rsp_ready`  in  1  host accepts result.
- `rsp_data`  out  32  read result.
- `pe_cfg_addr`  out  32  to PE `cfg_addr`.
- `pe_cfg_wdata`  out  32  to PE `cfg_wdata`.
- `pe_cfg_we`  out  1  to PE `cfg_we`.
- `pe_cfg_en`  out  1  to PE `cfg_en`.
- `pe_cfg_rdata`  in  32  from PE `cfg_rdata` (combinational in `pe_cfg_addr[4:0]`).
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `err`  out  1  sticky; set when a reserved command is dropped.

## Operation
- The FIFO stores {type, addr, wdata}. A push occurs when `cmd_valid && cmd_ready`. `cmd_ready = !full`, so there is no push while full, even on a same-cycle pop.
- FSM states: IDLE, ISSUE, HOLD, RD, RSP. All `pe_cfg_*`, `rsp_*` and `err` outputs are registered.
- IDLE with FIFO non-empty: pop the head and go to the next state:
  - WRITE/OP/OPRD go to ISSUE.
  - READ goes to RD.
  - Reserved type: drop it, set `err`, stay in IDLE. No PE activity.
- ISSUE, one cycle: `pe_cfg_addr=cmd_addr`, `pe_cfg_wdata=cmd_wdata`, `pe_cfg_we=1`, `pe_cfg_en` = 1 for OP/OPRD, 0 for WRITE. Next state is HOLD.
- HOLD, one cycle: `pe_cfg_we=0`, `pe_cfg_en=0`. `pe_cfg_addr` and `pe_cfg_wdata` are held unchanged, because the PE samples `cfg_wdata` unlatched in this cycle. The PE write commits at the edge ending HOLD.
  - OPRD goes to RD.
  - Otherwise, go to ISSUE/RD if the FIFO is non-empty (pop on that edge), else IDLE.
- RD, one cycle: `pe_cfg_addr={27'b0, addr[4:0]}`, `we=en=0`, `pe_cfg_wdata=0`. `pe_cfg_rdata` is captured into `rsp_data` and `rsp_valid=1` at the end of the cycle. Next state is RSP.
- RSP: `pe_cfg_*` are all 0. `rsp_valid` and `rsp_data` stay stable until `rsp_ready`. On the handshake edge `rsp_valid` clears, and the FSM pops the next command or returns to IDLE.
- In IDLE, all `pe_cfg_*` are 0.
- Commands with rd=0 are still issued; the PE ignores them.
- Ordering is strict FIFO. A READ that follows a WRITE/OP always observes the committed value, because HOLD precedes RD.

## Timing
- Reset values: `cmd_ready=1` after the reset edge, FIFO empty, FSM IDLE, `pe_cfg_*`=0, `rsp_valid=0`, `rsp_data=0`, `busy=0`, `err=0`.
- Latency: with a push at edge k into an empty, idle block, the ISSUE (or RD) cycle spans edges k+1 to k+2.
- Throughput:
  - WRITE/OP: 2 cycles each, back-to-back.
  - READ: 1 cycle, plus RSP for at least 1 cycle.
  - OPRD: 3 cycles, plus RSP.
- `rsp_valid` is first high the cycle after RD.
- Reset asserted in any state: at the next edge, FIFO contents and any pending response are discarded and all outputs take their reset values. A PE write latched in ISSUE but not yet committed is abandoned: `we` is 0 in the following cycle, so the PE sees no commit.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- Pointer wrap at DEPTH is seamless.

## Configuration
- `PE_SEQ_OPRD_EN` defined: `cmd_type` 11 is OPRD. It issues an OP, then automatically reads `rf[cmd_addr[4:0]]` and returns the result on `rsp_*`.
- Undefined: `cmd_type` 11 is reserved. It is popped and dropped, sets `err`, and causes no `pe_cfg` activity and no response.

## Test plan
- WRITE rd=3, wdata 0x00001234, then READ addr 3:
  - `pe_cfg_we` is a 1-cycle pulse.
  - `pe_cfg_wdata` is 0x1234 for exactly 2 cycles.
  - `rsp_data`=0x00001234.
- WRITE r1=5, WRITE r2=7, OP 0x02108804 (ADD r4=r1+r2), READ 4:
  - `pe_cfg_en`=1 only in the OP's ISSUE cycle.
  - `rsp_data`=0x0000000C.
- Backpressure: hold `rsp_ready=0` for 5 cycles after a READ.
  - `rsp_valid` stays 1 with `rsp_data` stable.
  - No `pe_cfg_we` pulses occur.
  - Pushing DEPTH more commands drives `cmd_ready` to 0.
- `cmd_type` 11 with the macro undefined: `err`=1, no `pe_cfg_we`, no `rsp_valid`.
- With `PE_SEQ_OPRD_EN`: r1=5, r2=7, OPRD 0x02208804 (SUB) → `rsp_data`=0xFFFFFFFE.
- Assert `rst_n`=0 during HOLD with 3 commands queued:
  - Next cycle all outputs are 0, `cmd_ready`=1, `busy`=0.
  - Queued commands are never issued after release.

Source files
------------

// File: rtl/pe_cfg_sequencer.sv
// PE config-port bus master: FIFO-queued WRITE/OP/READ commands; each write is held one extra cycle for the PE input latch.
// `define PE_SEQ_OPRD_EN makes cmd_type 11 an OP followed by readback (OPRD); otherwise type 11 is dropped and sets err.
module pe_cfg_sequencer #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [31:0] pe_cfg_addr,
   output logic [31:0] pe_cfg_wdata,
   output logic        pe_cfg_we,
   output logic        pe_cfg_en,
   input  logic [31:0] pe_cfg_rdata,
   output logic        busy,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
   localparam logic [1:0] T_WRITE = 2'b00;
   localparam logic [1:0] T_OP    = 2'b01;
   localparam logic [1:0] T_READ  = 2'b10;
`ifdef PE_SEQ_OPRD_EN
   localparam logic [1:0] T_OPRD  = 2'b11;
`endif

   typedef enum logic [2:0] {IDLE, ISSUE, HOLD, RD, RSP} state_t;

   typedef struct packed {
      logic [1:0]  typ;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   cmd_t          cur_q;
   cmd_t          cur_d;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          dispatch;
   state_t        state_q;
   state_t        state_d;
   logic          err_d;
   logic          rsp_valid_d;
   logic [31:0]   rsp_data_d;
   logic [31:0]   addr_d;
   logic [31:0]   wdata_d;
   logic          we_d;
   logic          en_d;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign head      = mem[rd_ptr];
   assign busy      = !empty || (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_type, cmd_addr, cmd_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      pop         = 1'b0;
      dispatch    = 1'b0;
      err_d       = err;
      rsp_valid_d = rsp_valid;
      rsp_data_d  = rsp_data;

      case (state_q)
         IDLE:  dispatch = 1'b1;
         ISSUE: state_d = HOLD;
         HOLD: begin
`ifdef PE_SEQ_OPRD_EN
            if (cur_q.typ == T_OPRD) begin
               state_d = RD;
            end else begin
               dispatch = 1'b1;
            end
`else
            dispatch = 1'b1;
`endif
         end
         RD: begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = pe_cfg_rdata;
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               dispatch    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Any state that finishes a command pulls the next one straight from the FIFO head.
      if (dispatch) begin
         state_d = IDLE;
         if (!empty) begin
            pop   = 1'b1;
            cur_d = head;
            case (head.typ)
               T_WRITE, T_OP: state_d = ISSUE;
               T_READ:        state_d = RD;
               default: begin
`ifdef PE_SEQ_OPRD_EN
                  state_d = ISSUE;
`else
                  err_d = 1'b1;
`endif
               end
            endcase
         end
      end

      addr_d  = '0;
      wdata_d = '0;
      we_d    = 1'b0;
      en_d    = 1'b0;
      case (state_d)
         ISSUE: begin
            addr_d  = cur_d.addr;
            wdata_d = cur_d.wdata;
            we_d    = 1'b1;
            en_d    = (cur_d.typ != T_WRITE);
         end
         // The PE reads cfg_wdata unlatched while committing, so address/data stay put.
         HOLD: begin
            addr_d  = cur_d.addr;
            wdata_d = cur_d.wdata;
         end
         RD:      addr_d = {27'b0, cur_d.addr[4:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cur_q        <= '0;
         err          <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         pe_cfg_addr  <= '0;
         pe_cfg_wdata <= '0;
         pe_cfg_we    <= 1'b0;
         pe_cfg_en    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         err          <= err_d;
         rsp_valid    <= rsp_valid_d;
         rsp_data     <= rsp_data_d;
         pe_cfg_addr  <= addr_d;
         pe_cfg_wdata <= wdata_d;
         pe_cfg_we    <= we_d;
         pe_cfg_en    <= en_d;
      end
   end

endmodule

// File: tb/tb_pe_cfg_sequencer.sv
// Bench for pe_cfg_sequencer: cycle-accurate vector table plus hand sequences, against a small behavioural PE.
module tb_pe_cfg_sequencer;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_type;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [31:0] pe_cfg_addr;
   logic [31:0] pe_cfg_wdata;
   logic        pe_cfg_we;
   logic        pe_cfg_en;
   logic [31:0] pe_cfg_rdata;
   logic        busy;
   logic        err;

   always #5 clk = ~clk;

   pe_cfg_sequencer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .pe_cfg_addr(pe_cfg_addr), .pe_cfg_wdata(pe_cfg_wdata), .pe_cfg_we(pe_cfg_we),
      .pe_cfg_en(pe_cfg_en), .pe_cfg_rdata(pe_cfg_rdata),
      .busy(busy), .err(err)
   );

   // PE: latches addr/we/en on one edge, commits on the next using the live cfg_wdata.
   // OP word: rd=[4:0], rs2=[14:10], rs1=[19:15], fn=[23:20] (1 ADD, 2 SUB).
   logic [31:0] rf [32];
   logic        lat_we;
   logic        lat_en;
   logic [31:0] lat_addr;
   assign pe_cfg_rdata = rf[pe_cfg_addr[4:0]];

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) rf[r] <= '0;
         lat_we   <= 1'b0;
         lat_en   <= 1'b0;
         lat_addr <= '0;
      end else begin
         if (lat_we && !lat_en) begin
            rf[lat_addr[4:0]] <= pe_cfg_wdata;
         end else if (lat_we && lat_en) begin
            case (lat_addr[23:20])
               4'd1:    rf[lat_addr[4:0]] <= rf[lat_addr[19:15]] + rf[lat_addr[14:10]];
               4'd2:    rf[lat_addr[4:0]] <= rf[lat_addr[19:15]] - rf[lat_addr[14:10]];
               default: ;
            endcase
         end
         lat_we   <= pe_cfg_we;
         lat_en   <= pe_cfg_en;
         lat_addr <= pe_cfg_addr;
      end
   end

   int we_cnt  = 0;
   int rsp_cnt = 0;
   always @(posedge clk) begin
      if (pe_cfg_we === 1'b1) we_cnt <= we_cnt + 1;
      if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
   end

   typedef struct packed {
      logic        rst_n;
      logic        vld;
      logic [1:0]  typ;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rr;
   } in_t;

   typedef struct packed {
      logic        crdy;
      logic        we;
      logic        en;
      logic [31:0] pa;
      logic [31:0] pw;
      logic        rv;
      logic [31:0] rd;
      logic        bsy;
      logic        er;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   vec_t vecs [18];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic vec_t v(input int rst, input int vld, input int t, input logic [31:0] a,
                              input logic [31:0] wd, input int rr, input int crdy, input int we,
                              input int en, input logic [31:0] pa, input logic [31:0] pw,
                              input int rv, input logic [31:0] rd, input int bsy, input int er);
      vec_t x;
      x.i.rst_n = (rst != 0);
      x.i.vld   = (vld != 0);
      x.i.typ   = 2'(t);
      x.i.addr  = a;
      x.i.wdata = wd;
      x.i.rr    = (rr != 0);
      x.o.crdy  = (crdy != 0);
      x.o.we    = (we != 0);
      x.o.en    = (en != 0);
      x.o.pa    = pa;
      x.o.pw    = pw;
      x.o.rv    = (rv != 0);
      x.o.rd    = rd;
      x.o.bsy   = (bsy != 0);
      x.o.er    = (er != 0);
      return x;
   endfunction

   function automatic out_t sample();
      out_t s;
      s.crdy = cmd_ready;
      s.we   = pe_cfg_we;
      s.en   = pe_cfg_en;
      s.pa   = pe_cfg_addr;
      s.pw   = pe_cfg_wdata;
      s.rv   = rsp_valid;
      s.rd   = rsp_data;
      s.bsy  = busy;
      s.er   = err;
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait expired, got none expected event", nm);
   endtask

   task automatic wait_rsp(input int max, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < max; c++) begin
         step();
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int max, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < max; c++) begin
         step();
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit   ok;
      bit   stable;
      int   we_mark;
      int   rsp_mark;
      out_t rexp;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 2'b00;
      cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;

      //            rst vld typ addr          wdata        rr | rdy we en pe_addr       pe_wdata     rv rsp_data      bsy err
      vecs[0]  = v(0, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h0,        32'h0,       0, 32'h0,        0, 0);
      vecs[1]  = v(1, 1, 0, 32'h3,        32'h1234,    1,   1, 0, 0, 32'h0,        32'h0,       0, 32'h0,        1, 0);
      vecs[2]  = v(1, 1, 2, 32'h3,        32'h0,       1,   1, 1, 0, 32'h3,        32'h1234,    0, 32'h0,        1, 0);
      vecs[3]  = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h3,        32'h1234,    0, 32'h0,        1, 0);
      vecs[4]  = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h3,        32'h0,       0, 32'h0,        1, 0);
      vecs[5]  = v(1, 0, 0, 32'h0,        32'h0,       0,   1, 0, 0, 32'h0,        32'h0,       1, 32'h1234,     1, 0);
      vecs[6]  = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h0,        32'h0,       0, 32'h1234,     0, 0);
      vecs[7]  = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h0,        32'h0,       0, 32'h1234,     0, 0);
      vecs[8]  = v(1, 1, 0, 32'h1,        32'h5,       1,   1, 0, 0, 32'h0,        32'h0,       0, 32'h1234,     1, 0);
      vecs[9]  = v(1, 1, 0, 32'h2,        32'h7,       1,   1, 1, 0, 32'h1,        32'h5,       0, 32'h1234,     1, 0);
      vecs[10] = v(1, 1, 1, 32'h02108804, 32'h0,       1,   1, 0, 0, 32'h1,        32'h5,       0, 32'h1234,     1, 0);
      vecs[11] = v(1, 1, 2, 32'h4,        32'h0,       1,   1, 1, 0, 32'h2,        32'h7,       0, 32'h1234,     1, 0);
      vecs[12] = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h2,        32'h7,       0, 32'h1234,     1, 0);
      vecs[13] = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 1, 1, 32'h02108804, 32'h0,       0, 32'h1234,     1, 0);
      vecs[14] = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h02108804, 32'h0,       0, 32'h1234,     1, 0);
      vecs[15] = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h4,        32'h0,       0, 32'h1234,     1, 0);
      vecs[16] = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h0,        32'h0,       1, 32'hC,        1, 0);
      vecs[17] = v(1, 0, 0, 32'h0,        32'h0,       1,   1, 0, 0, 32'h0,        32'h0,       0, 32'hC,        0, 0);

      for (int i = 0; i < 18; i++) begin
         rst_n     = vecs[i].i.rst_n;
         cmd_valid = vecs[i].i.vld;
         cmd_type  = vecs[i].i.typ;
         cmd_addr  = vecs[i].i.addr;
         cmd_wdata = vecs[i].i.wdata;
         rsp_ready = vecs[i].i.rr;
         step();
         chk($sformatf("vec%0d", i), 128'(sample()), 128'(vecs[i].o));
      end
      cmd_valid = 1'b0;

      // Response backpressure while the FIFO fills up.
      cmd_valid = 1'b1; cmd_type = 2'b10; cmd_addr = 32'h3; cmd_wdata = '0; rsp_ready = 1'b0;
      step();
      cmd_valid = 1'b0;
      wait_rsp(10, ok);
      if (!ok) timeout("bp_rsp_wait");
      chk("bp_rsp_data", 128'(rsp_data), 128'(32'h1234));
      we_mark = we_cnt;
      stable  = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         cmd_valid = 1'b1; cmd_type = 2'b00; cmd_addr = 32'd10; cmd_wdata = 32'h100 + k;
         step();
         if (!(rsp_valid === 1'b1 && rsp_data === 32'h1234)) stable = 1'b0;
      end
      chk("bp_full_ready", 128'(cmd_ready), 128'(1'b0));
      cmd_addr = 32'd11; cmd_wdata = 32'hBAD;
      step();
      cmd_valid = 1'b0;
      if (!(rsp_valid === 1'b1 && rsp_data === 32'h1234)) stable = 1'b0;
      chk("bp_rsp_stable", 128'(stable), 128'(1'b1));
      chk("bp_no_we", 128'(we_cnt - we_mark), 128'(0));
      rsp_ready = 1'b1;
      wait_idle(100, ok);
      if (!ok) timeout("bp_drain_wait");
      chk("bp_drain_writes", 128'(we_cnt - we_mark), 128'(DEPTH));
      cmd_valid = 1'b1; cmd_type = 2'b10; cmd_addr = 32'd10;
      step();
      cmd_valid = 1'b0;
      wait_rsp(10, ok);
      if (!ok) timeout("bp_order_wait");
      chk("bp_order_data", 128'(rsp_data), 128'(32'h100 + DEPTH - 1));
      wait_idle(10, ok);

`ifdef PE_SEQ_OPRD_EN
      cmd_valid = 1'b1; cmd_type = 2'b00; cmd_addr = 32'd1; cmd_wdata = 32'd5;
      step();
      cmd_addr = 32'd2; cmd_wdata = 32'd7;
      step();
      cmd_type = 2'b11; cmd_addr = 32'h02208804; cmd_wdata = '0;
      step();
      cmd_valid = 1'b0;
      wait_rsp(40, ok);
      if (!ok) timeout("oprd_wait");
      chk("oprd_data", 128'(rsp_data), 128'(32'hFFFF_FFFE));
      chk("oprd_no_err", 128'(err), 128'(1'b0));
      wait_idle(10, ok);
`else
      we_mark  = we_cnt;
      rsp_mark = rsp_cnt;
      cmd_valid = 1'b1; cmd_type = 2'b11; cmd_addr = 32'd5; cmd_wdata = 32'd9;
      step();
      cmd_valid = 1'b0;
      repeat (6) step();
      chk("rsv_err", 128'(err), 128'(1'b1));
      chk("rsv_no_we", 128'(we_cnt - we_mark), 128'(0));
      chk("rsv_no_rsp", 128'(rsp_cnt - rsp_mark), 128'(0));
      chk("rsv_idle", 128'(busy), 128'(1'b0));
`endif

      // Reset during HOLD of the second write with three commands still queued.
      for (int k = 0; k < 5; k++) begin
         cmd_valid = 1'b1; cmd_type = 2'b00; cmd_addr = 32'd20 + k; cmd_wdata = 32'hA0 + k;
         step();
      end
      cmd_valid = 1'b0;
      chk("rst_pre_hold", 128'({pe_cfg_we, pe_cfg_addr, pe_cfg_wdata, busy}),
          128'({1'b0, 32'd21, 32'hA1, 1'b1}));
      rst_n = 1'b0;
      step();
      rexp      = '0;
      rexp.crdy = 1'b1;
      chk("rst_outputs", 128'(sample()), 128'(rexp));
      rst_n   = 1'b1;
      we_mark = we_cnt;
      repeat (12) step();
      chk("rst_no_issue", 128'(we_cnt - we_mark), 128'(0));
      chk("rst_idle", 128'(busy), 128'(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
